// File: rtl/list_cmd_queue_pkg.sv
// list_cmd_queue_pkg
//   Shared types for the list command front-end: the 3-bit list opcode
//   encoding, the front-end FSM state type and the index-width helper.
//   No ports (package).
package list_cmd_queue_pkg;

    typedef enum logic [2:0] {
        OP_READ     = 3'd0,
        OP_WRITE    = 3'd1,
        OP_FIND_ALL = 3'd2,
        OP_FIND_1ST = 3'd3,
        OP_SUM      = 3'd4,
        OP_SORT_ASC = 3'd5,
        OP_SORT_DES = 3'd6,
        OP_ILLEGAL  = 3'd7
    } list_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Index must be able to express LENGTH itself so out-of-range is visible.
    function automatic int calc_len_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/list_cmd_queue_if.sv
// list_cmd_queue_if
//   Command (producer -> queue) and response (queue -> consumer) valid/ready
//   channels of the list command front-end.
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_index : command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_error        : response channel
//   master: producer/consumer side; slave: the queue.
//   LENGTH_WIDTH must equal calc_len_width(LENGTH) of the attached queue.
interface list_cmd_queue_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int LENGTH_WIDTH = 4
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [2:0]                       cmd_op;
    logic [DATA_WIDTH-1:0]            cmd_data;
    logic [LENGTH_WIDTH-1:0]          cmd_index;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data;
    logic                             rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_index, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_index, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/list_cmd_queue_fifo.sv
// list_cmd_queue_fifo
//   Synchronous command FIFO, DEPTH entries (power of 2, >= 2), no bypass.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write request/data, ignored while full
//   pop, dout    : read request / head entry (valid while !empty)
//   full, empty  : occupancy flags derived from the internal count
module list_cmd_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged on the registered count: a same-cycle pop does not free a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/list_cmd_queue.sv
// list_cmd_queue
//   Command front-end owning the list block's op inputs. Buffers commands in
//   a FIFO, prechecks them, issues one at a time with a single-cycle op_en,
//   waits for op_done and returns the list's result on the response channel.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : cmd_* valid/ready command in, rsp_* valid/ready response out
//   list_op_sel/list_op_en/list_data_in/list_index_in : drive the list
//   list_data_out/list_op_done/list_op_error          : from the list
//   Optional macro LIST_CMD_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES
//   cycles with an error response; without it WAIT holds indefinitely.
module list_cmd_queue
    import list_cmd_queue_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  LENGTH         = 8,
    parameter int  FIFO_DEPTH     = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int LENGTH_WIDTH   = calc_len_width(LENGTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    list_cmd_queue_if.slave                    bus,
    output logic [2:0]                         list_op_sel,
    output logic                               list_op_en,
    output logic [DATA_WIDTH-1:0]              list_data_in,
    output logic [LENGTH_WIDTH-1:0]            list_index_in,
    input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] list_data_out,
    input  logic                               list_op_done,
    input  logic                               list_op_error
);
    localparam int CMD_W = 3 + DATA_WIDTH + LENGTH_WIDTH;
    localparam int RSP_W = LENGTH_WIDTH + DATA_WIDTH;

    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]        fifo_head;
    logic [2:0]              head_op;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [LENGTH_WIDTH-1:0] head_index;
    logic                    precheck_ok;

    state_e                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [LENGTH_WIDTH-1:0] index_q, index_d;
    logic [RSP_W-1:0]        rsp_data_q, rsp_data_d;
    logic                    rsp_error_q, rsp_error_d;

`ifdef LIST_CMD_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
`endif

    list_cmd_queue_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .din   ({bus.cmd_op, bus.cmd_data, bus.cmd_index}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready = !fifo_full;
    assign head_op       = fifo_head[CMD_W-1 -: 3];
    assign head_data     = fifo_head[LENGTH_WIDTH +: DATA_WIDTH];
    assign head_index    = fifo_head[LENGTH_WIDTH-1:0];

    // Only READ/WRITE address a single element; the other ops ignore index.
    assign precheck_ok = !((head_op == OP_ILLEGAL) ||
                           (((head_op == OP_READ) || (head_op == OP_WRITE)) &&
                            (head_index >= LENGTH_WIDTH'(LENGTH))));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        index_d     = index_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        fifo_pop    = 1'b0;
`ifdef LIST_CMD_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (precheck_ok) begin
                        op_d    = head_op;
                        data_d  = head_data;
                        index_d = head_index;
                        state_d = ST_ISSUE;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef LIST_CMD_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // op_done takes priority over an expiring timeout.
                if (list_op_done) begin
                    rsp_data_d  = list_data_out;
                    rsp_error_d = list_op_error;
                    state_d     = ST_RESP;
                end
`ifdef LIST_CMD_TIMEOUT_EN
                else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            index_q     <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
`ifdef LIST_CMD_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            index_q     <= index_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
`ifdef LIST_CMD_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign list_op_sel   = op_q;
    assign list_op_en    = (state_q == ST_ISSUE);
    assign list_data_in  = data_q;
    assign list_index_in = index_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_list_cmd_queue.sv
// tb_list_cmd_queue
//   Randomized scoreboard bench for list_cmd_queue. A behavioural list
//   stand-in answers issued ops; a reference array predicts each response at
//   command acceptance, and a monitor compares responses in order.
module tb_list_cmd_queue;
    localparam int DW  = 32;
    localparam int LEN = 8;
    localparam int LW  = 4;
    localparam int RW  = LW + DW;

    typedef logic [DW-1:0] arr_t [LEN];

    logic          clk, rst;
    logic [2:0]    list_op_sel;
    logic          list_op_en;
    logic [DW-1:0] list_data_in;
    logic [LW-1:0] list_index_in;
    logic [RW-1:0] list_data_out;
    logic          list_op_done, list_op_error;

    list_cmd_queue_if #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) bus ();

    list_cmd_queue #(
        .DATA_WIDTH(DW), .LENGTH(LEN), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .list_op_sel(list_op_sel), .list_op_en(list_op_en),
        .list_data_in(list_data_in), .list_index_in(list_index_in),
        .list_data_out(list_data_out), .list_op_done(list_op_done),
        .list_op_error(list_op_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [RW:0] exp_q [$];
    arr_t ref_arr, stub_arr;
    bit   stub_pending = 0, stray_en = 1, rand_rdy = 0, exp_timeout = 0;
    int   stub_cnt, hang_cycles = 0, fix_delay = 0, op_en_count = 0, op_en_cyc = 0, last_acc = 0;
    logic [RW-1:0] stub_res;
    logic stub_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event at cycle %0d", nm, cyc);
    endtask

    function automatic bit is_illegal(input logic [2:0] op, input logic [LW-1:0] idx);
        return (op == 3'd7) || ((op <= 3'd1) && (int'(idx) >= LEN));
    endfunction

    // Reference list semantics used by both the list stand-in and the predictor.
    function automatic void list_apply(input arr_t a, input logic [2:0] op, input logic [DW-1:0] d,
                                       input logic [LW-1:0] idx, output arr_t o,
                                       output logic [RW-1:0] r, output logic e);
        logic [DW-1:0] t;
        bit found;
        o = a; r = '0; e = 1'b0; found = 0;
        case (op)
            3'd0: r = RW'(a[int'(idx)]);
            3'd1: o[int'(idx)] = d;
            3'd2: for (int i = 0; i < LEN; i++) if (a[i] == d) r = r + RW'(1);
            3'd3: begin
                for (int i = LEN - 1; i >= 0; i--) if (a[i] == d) begin r = RW'(i); found = 1; end
                e = !found;
            end
            3'd4: for (int i = 0; i < LEN; i++) r = r + RW'(a[i]);
            3'd5, 3'd6:
                for (int i = 0; i < LEN - 1; i++)
                    for (int j = 0; j < LEN - 1 - i; j++)
                        if ((op == 3'd5) ? (o[j] > o[j+1]) : (o[j] < o[j+1])) begin
                            t = o[j]; o[j] = o[j+1]; o[j+1] = t;
                        end
            default: e = 1'b1;
        endcase
    endfunction

    // List stand-in: answers each op_en after a delay, pulses op_done out of
    // reset and at random while nothing is outstanding.
    initial begin
        arr_t n;
        list_op_done = 1'b1; list_op_error = 1'b0; list_data_out = '0;
        for (int i = 0; i < LEN; i++) stub_arr[i] = '0;
        forever begin
            @(posedge clk); #1;
            list_op_done = 1'b0; list_op_error = 1'b0; list_data_out = RW'($urandom);
            if (list_op_en) begin
                op_en_count++; op_en_cyc = cyc;
                chk("issue_overlap", 64'(stub_pending), 64'(0));
                chk("issue_legal", 64'(is_illegal(list_op_sel, list_index_in)), 64'(0));
                if (!is_illegal(list_op_sel, list_index_in)) begin
                    list_apply(stub_arr, list_op_sel, list_data_in, list_index_in, n, stub_res, stub_err);
                    stub_arr = n;
                end
                stub_pending = 1;
                stub_cnt = (hang_cycles > 0) ? hang_cycles : (fix_delay > 0) ? fix_delay : $urandom_range(1, 3);
                hang_cycles = 0;
            end else if (stub_pending) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    list_op_done = 1'b1; list_data_out = stub_res; list_op_error = stub_err;
                    stub_pending = 0;
                end
            end else if (rst) begin
                list_op_done = 1'b1;
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                list_op_done = 1'b1; list_op_error = 1'($urandom);
            end
        end
    end

    // Monitor: compare every accepted response against the scoreboard head.
    initial begin
        logic [RW:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) fail("rsp_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("rsp", 64'({bus.rsp_error, bus.rsp_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called and returns just after a rising edge.
    task automatic push_cmd(input logic [2:0] op, input logic [DW-1:0] d, input logic [LW-1:0] idx,
                            output int waited);
        arr_t n; logic [RW-1:0] r; logic er;
        waited = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d; bus.cmd_index = idx;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            @(posedge clk); #1;
            waited++;
            if (waited > 300) begin fail("cmd_accept"); bus.cmd_valid = 1'b0; return; end
        end
        last_acc = cyc;
        if (is_illegal(op, idx)) exp_q.push_back({1'b1, RW'(0)});
        else begin
            list_apply(ref_arr, op, d, idx, n, r, er);
            ref_arr = n;
            exp_q.push_back(exp_timeout ? {1'b1, RW'(0)} : {er, r});
        end
        exp_timeout = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rsp(output int c);
        for (int k = 0; k < 300; k++) begin
            if (bus.rsp_valid) begin c = cyc; return; end
            step(1);
        end
        c = -1000;
        fail("rsp_wait");
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && !stub_pending && !bus.rsp_valid) return;
            step(1);
        end
        fail("drain");
    endtask

    initial begin
        int w, c, n0, acc, seen;
        logic [2:0] op;
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c, n0, acc, seen;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0; bus.cmd_index = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < LEN; i++) ref_arr[i] = '0;
        step(3);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_error, bus.rsp_data}), 64'(0));
        chk("rst_list", 64'({list_op_en, list_op_sel, list_data_in, list_index_in}), 64'(0));
        rst = 1'b0;
        step(4);
        chk("post_rst_quiet", 64'({list_op_en, bus.rsp_valid}), 64'(0));

        // Write then read back, list answering next cycle.
        fix_delay = 1; bus.rsp_ready = 1'b1;
        push_cmd(3'd1, 32'hA5, 4'd2, w);
        push_cmd(3'd0, 32'h0, 4'd2, w);
        drain();

        // First-command latency into an empty FIFO.
        push_cmd(3'd4, 32'h0, 4'd0, w);
        acc = last_acc;
        wait_rsp(c);
        chk("lat_op_en", 64'(op_en_cyc - acc), 64'(2));
        chk("lat_rsp", 64'(c - acc), 64'(4));
        drain();

        // Out-of-range READ/WRITE and illegal opcode never reach the list.
        n0 = op_en_count;
        push_cmd(3'd0, 32'h0, 4'd8, w);
        push_cmd(3'd1, 32'h77, 4'd9, w);
        push_cmd(3'd7, 32'h0, 4'd0, w);
        drain();
        chk("precheck_no_issue", 64'(op_en_count - n0), 64'(0));
        push_cmd(3'd7, 32'h1, 4'd1, w);
        push_cmd(3'd4, 32'h0, 4'd0, w);
        drain();

        // Stall: one command parked in RESP, then FIFO fills to 4.
        bus.rsp_ready = 1'b0;
        n0 = op_en_count;
        push_cmd(3'd4, 32'h0, 4'd0, w);
        wait_rsp(c);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(3'd1, DW'(i + 10), LW'(i + 3), w);
            if (w == 0) seen++;
        end
        chk("stall_accepted", 64'(seen), 64'(4));
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_data = '0; bus.cmd_index = 4'd4;
        @(negedge clk);
        chk("stall_full_ready", 64'(bus.cmd_ready), 64'(0));
        chk("stall_head_issued", 64'(op_en_count - n0), 64'(1));
        step(1);
        bus.rsp_ready = 1'b1;
        push_cmd(3'd0, 32'h0, 4'd4, w);
        drain();

        // List never answers for 100 cycles.
        hang_cycles = 100; stray_en = 0;
`ifdef LIST_CMD_TIMEOUT_EN
        exp_timeout = 1;
        push_cmd(3'd4, 32'h0, 4'd0, w);
        wait_rsp(c);
        chk("timeout_lat", 64'(c - op_en_cyc), 64'(65));
`else
        push_cmd(3'd4, 32'h0, 4'd0, w);
        seen = 0;
        for (int k = 0; k < 99; k++) begin
            if (bus.rsp_valid) seen = 1;
            step(1);
        end
        chk("no_timeout_hold", 64'(seen), 64'(0));
`endif
        drain();

        // Reset during WAIT, late op_done afterwards.
        hang_cycles = 30;
        n0 = op_en_count;
        push_cmd(3'd4, 32'h0, 4'd0, w);
        for (int k = 0; k < 20 && op_en_count == n0; k++) step(1);
        if (op_en_count == n0) fail("rst_test_issue");
        step(4);
        rst = 1'b1;
        exp_q.delete();
        step(2);
        rst = 1'b0;
        n0 = op_en_count; seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.rsp_valid) seen = 1;
            step(1);
        end
        chk("rst_no_rsp", 64'(seen), 64'(0));
        chk("rst_no_issue", 64'(op_en_count - n0), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        drain();

        // Random traffic with random consumer back-pressure and stray pulses.
        stray_en = 1; fix_delay = 0; rand_rdy = 1;
        for (int k = 0; k < 150; k++) begin
            push_cmd(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 5)),
                     LW'($urandom_range(0, 10)), w);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 5));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
